// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown scoreboard for load/ALU/mul hazards
// Holds bubbles in ID until every source is forwardable and the mul unit is free.
module hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int MEM_LAT = 1,
  parameter int MUL_LAT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic          id_is_branch,
  input  logic          id_is_store,
  input  logic [AW-1:0] id_dest,
  input  logic [1:0]    id_dest_kind,
  output logic          PcWrite,
  output logic          IF_ID_write,
  output logic          stall,
  output logic [15:0]   stall_cycles
);

  localparam int NREG = 1 << AW;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_ALU  = 2'b01;
  localparam logic [1:0] KIND_LOAD = 2'b10;
  localparam logic [1:0] KIND_MUL  = 2'b11;

  localparam logic [2:0] ALU_CNT  = 3'd1;
  localparam logic [2:0] LOAD_CNT = 3'(MEM_LAT + 1);
  localparam logic [2:0] MUL_CNT  = 3'(MUL_LAT + 1);
  localparam logic [2:0] MUL_BUSY = 3'(MUL_LAT);

  logic [2:0]  c_q [NREG];
  logic [2:0]  c_d [NREG];
  logic [2:0]  mul_busy_q, mul_busy_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic [2:0]  c_rs, c_rt;
  logic        rs_ok, rt_ok, struct_ok, stall_w, issue;

  // Register 0 is hard-wired: its count is never consulted.
  assign c_rs = (id_rs == '0) ? 3'd0 : c_q[id_rs];
  assign c_rt = (id_rt == '0) ? 3'd0 : c_q[id_rt];

  always_comb begin
    rs_ok = 1'b1;
    if (id_uses_rs) begin
      rs_ok = id_is_branch ? (c_rs == 3'd0) : (c_rs <= 3'd1);
    end
    rt_ok = 1'b1;
    if (id_uses_rt || id_is_store) begin
      if (id_is_branch) begin
        rt_ok = (c_rt == 3'd0);
      end else if (id_is_store) begin
        // Store data is consumed in MEM, one stage later than EX operands.
        rt_ok = (c_rt <= 3'd2);
      end else begin
        rt_ok = (c_rt <= 3'd1);
      end
    end
    struct_ok = !((id_dest_kind == KIND_MUL) && (mul_busy_q != 3'd0));
    stall_w   = id_valid && !(rs_ok && rt_ok && struct_ok);
  end

  assign issue       = id_valid && !stall_w;
  assign stall       = stall_w;
  assign PcWrite     = !stall_w;
  assign IF_ID_write = !stall_w;
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      c_d[r] = (c_q[r] != 3'd0) ? c_q[r] - 3'd1 : 3'd0;
    end
    if (issue && (id_dest != '0)) begin
      case (id_dest_kind)
        KIND_ALU:  c_d[id_dest] = ALU_CNT;
        KIND_LOAD: c_d[id_dest] = LOAD_CNT;
        KIND_MUL:  c_d[id_dest] = MUL_CNT;
        KIND_NONE: c_d[id_dest] = c_d[id_dest];
        default:   c_d[id_dest] = c_d[id_dest];
      endcase
    end
    c_d[0] = 3'd0;

    mul_busy_d = (mul_busy_q != 3'd0) ? mul_busy_q - 3'd1 : 3'd0;
    if (issue && (id_dest_kind == KIND_MUL)) begin
      mul_busy_d = MUL_BUSY;
    end

    stall_cycles_d = stall_cycles_q;
    if (stall_w && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        c_q[r] <= 3'd0;
      end
      mul_busy_q     <= 3'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        c_q[r] <= c_d[r];
      end
      mul_busy_q     <= mul_busy_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_uses_rs, id_uses_rt, id_is_branch, id_is_store;
  logic [1:0]  id_dest_kind;
  logic        PcWrite, IF_ID_write, stall;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_is_store(id_is_store),
    .id_dest(id_dest), .id_dest_kind(id_dest_kind),
    .PcWrite(PcWrite), .IF_ID_write(IF_ID_write), .stall(stall),
    .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urs;
    logic        urt;
    logic        br;
    logic        st;
    logic [4:0]  dest;
    logic [1:0]  kind;
    logic        exp_stall;
    logic [15:0] exp_sc;
  } vec_t;

  localparam int NV = 46;
  vec_t tbl [NV];

  function automatic vec_t mk(int v, int rs, int rt, int urs, int urt, int br, int st,
                              int dest, int kind, int es, int sc);
    vec_t x;
    x.v = 1'(v);  x.rs = 5'(rs);  x.rt = 5'(rt);
    x.urs = 1'(urs); x.urt = 1'(urt); x.br = 1'(br); x.st = 1'(st);
    x.dest = 5'(dest); x.kind = 2'(kind);
    x.exp_stall = 1'(es); x.exp_sc = 16'(sc);
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t x);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt;
    id_uses_rs = x.urs; id_uses_rt = x.urt;
    id_is_branch = x.br; id_is_store = x.st;
    id_dest = x.dest; id_dest_kind = x.kind;
  endtask

  task automatic check_outs(input string tag, input logic es);
    check({tag, " stall"}, 32'(stall), 32'(es));
    check({tag, " PcWrite"}, 32'(PcWrite), 32'(!es));
    check({tag, " IF_ID_write"}, 32'(IF_ID_write), 32'(!es));
  endtask

  vec_t idle_v, mul12_v, brq_v, satv;
  int   pat_err;

  initial begin
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load -> R-type
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 0);
    tbl[1]  = mk(1, 8, 9, 1, 1, 0, 0, 11, 1, 1, 0);
    tbl[2]  = mk(1, 8, 9, 1, 1, 0, 0, 11, 1, 0, 1);
    for (int i = 3; i <= 6; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // load -> beq, then ALU -> beq
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 1);
    tbl[8]  = mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 1, 1);
    tbl[9]  = mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 1, 2);
    tbl[10] = mk(1, 8, 9, 1, 1, 1, 0, 0, 0, 0, 3);
    tbl[11] = mk(1, 1, 2, 1, 1, 0, 0, 9, 1, 0, 3);
    tbl[12] = mk(1, 9, 3, 1, 1, 1, 0, 0, 0, 1, 3);
    tbl[13] = mk(1, 9, 3, 1, 1, 1, 0, 0, 0, 0, 4);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    // load -> sw data (no stall), load -> sw address (1 stall)
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 4);
    tbl[17] = mk(1, 0, 8, 1, 0, 0, 1, 0, 0, 0, 4);
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 4);
    tbl[19] = mk(1, 8, 0, 1, 0, 0, 1, 0, 0, 1, 4);
    tbl[20] = mk(1, 8, 0, 1, 0, 0, 1, 0, 0, 0, 5);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    // mul -> independent mul (structural)
    tbl[23] = mk(1, 0, 0, 0, 0, 0, 0, 10, 3, 0, 5);
    tbl[24] = mk(1, 1, 2, 1, 1, 0, 0, 12, 3, 1, 5);
    tbl[25] = mk(1, 1, 2, 1, 1, 0, 0, 12, 3, 1, 6);
    tbl[26] = mk(1, 1, 2, 1, 1, 0, 0, 12, 3, 1, 7);
    tbl[27] = mk(1, 1, 2, 1, 1, 0, 0, 12, 3, 0, 8);
    for (int i = 28; i <= 32; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    // mul -> R-type reading its result
    tbl[33] = mk(1, 0, 0, 0, 0, 0, 0, 10, 3, 0, 8);
    tbl[34] = mk(1, 10, 0, 1, 0, 0, 0, 11, 1, 1, 8);
    tbl[35] = mk(1, 10, 0, 1, 0, 0, 0, 11, 1, 1, 9);
    tbl[36] = mk(1, 10, 0, 1, 0, 0, 0, 11, 1, 1, 10);
    tbl[37] = mk(1, 10, 0, 1, 0, 0, 0, 11, 1, 0, 11);
    // $0 never tracked; same register on both sources stalls once
    tbl[38] = mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 11);
    tbl[39] = mk(1, 0, 0, 1, 1, 0, 0, 13, 1, 0, 11);
    tbl[40] = mk(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 11);
    tbl[41] = mk(1, 8, 8, 1, 1, 0, 0, 11, 1, 1, 11);
    tbl[42] = mk(1, 8, 8, 1, 1, 0, 0, 11, 1, 0, 12);
    // invalid slot never stalls even with pending hazards
    tbl[43] = mk(1, 0, 0, 0, 0, 0, 0, 14, 3, 0, 12);
    tbl[44] = mk(0, 14, 0, 1, 0, 0, 0, 15, 3, 0, 12);
    tbl[45] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);

    reset = 1'b1;
    drive(idle_v);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_outs("reset", 1'b0);
    check("reset stall_cycles", 32'(stall_cycles), 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_outs($sformatf("row%0d", i), tbl[i].exp_stall);
      check($sformatf("row%0d stall_cycles", i), 32'(stall_cycles), 32'(tbl[i].exp_sc));
    end

    // drain pending counts, then reset in the 2nd cycle of a mul stall
    drive(idle_v);
    repeat (6) @(negedge clk);
    check("drained stall_cycles", 32'(stall_cycles), 32'd12);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 10, 3, 0, 0));
    #1;
    check_outs("rst mul issue", 1'b0);
    mul12_v = mk(1, 1, 2, 1, 1, 0, 0, 12, 3, 1, 0);
    @(negedge clk);
    drive(mul12_v);
    #1;
    check_outs("rst stall1", 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outs("rst stall2", 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outs("after reset", 1'b0);
    check("after reset stall_cycles", 32'(stall_cycles), 32'd0);
    brq_v = mk(1, 10, 12, 1, 1, 1, 0, 0, 0, 0, 0);
    drive(brq_v);
    #1;
    check_outs("after reset c clear", 1'b0);

    // saturation: self-dependent mul branch gives 4 stalls per 5 cycles
    satv = mk(1, 10, 0, 1, 0, 1, 0, 10, 3, 0, 0);
    pat_err = 0;
    for (int g = 0; g < 17500; g++) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        drive(satv);
        #1;
        if (stall !== (k != 0)) pat_err++;
      end
      if (g == 16382) begin
        @(negedge clk);
        drive(idle_v);
        #1;
        check("sat near stall_cycles", 32'(stall_cycles), 32'd65532);
      end
    end
    @(negedge clk);
    drive(idle_v);
    #1;
    check("sat pattern errors", 32'(pat_err), 32'd0);
    check("sat stall_cycles", 32'(stall_cycles), 32'h0000FFFF);
    check_outs("sat idle", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
